// File: rtl/ltc5548_sys_nios2_gen2_0_cpu_debug_ocimem.sv
// Purpose : debug OCI RAM shared by JTAG debug commands and a CPU Avalon-MM slave port.
// Latency : JTAG read -> MonDReg/monitor_ready 2 cycles after the pulse; CPU read 2 cycles; CPU write 1 cycle.
// Backpressure: avs_waitrequest stalls the CPU while JTAG owns the RAM; JTAG pulses that cannot be served are dropped and flagged on monitor_error.
//
// Ports:
//   clk, reset_n              system clock, asynchronous active-low reset
//   jdo, take_*_ocimem_*      JTAG command data and 1-cycle command pulses from the debug slave
//   avs_*                     CPU Avalon-MM slave (address, read, write, writedata, byteenable,
//                             debugaccess, readdata, waitrequest)
//   MonDReg                   last JTAG read data
//   monitor_ready             last JTAG access has completed
//   monitor_error             sticky flag: a JTAG command was dropped
//
// Configuration macro: OCIMEM_AUTOINC_EN
//   defined   -> JTAG pointer post-increments (with wrap) after every JTAG read/write
//   undefined -> JTAG pointer only moves on an address load
module ltc5548_sys_nios2_gen2_0_cpu_debug_ocimem #(
  parameter int          ADDR_W       = 8,
  parameter int unsigned RESET_ADDR   = 0,
  parameter int unsigned PROTECT_BASE = 8'hC0
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [37:0]       jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic              take_no_action_ocimem_a,
  input  logic [ADDR_W-1:0] avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  input  logic              avs_debugaccess,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_JRD   = 3'd1,
    S_JCAP  = 3'd2,
    S_JWR   = 3'd3,
    S_CRD   = 3'd4,
    S_CDONE = 3'd5
  } state_t;

  state_t state, state_nxt;

  // Storage and datapath registers
  logic [31:0]       mem [DEPTH];
  logic [31:0]       rd_q;       // RAM output register, shared by both masters
  logic [31:0]       rd_hold;    // CPU read data, held until the next CPU read completes
  logic [31:0]       wdat_q;     // JTAG write data, latched when the write is accepted
  logic [ADDR_W-1:0] ptr;
  logic [ADDR_W-1:0] ptr_inc;

  // Control decoded by the FSM
  logic              ram_we;
  logic              ram_we_g;
  logic              ram_rd;
  logic [3:0]        ram_be;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdat;
  logic              ptr_ld;
  logic              ptr_step;
  logic              wdat_ld;
  logic              mon_cap;
  logic              rdy_set;
  logic              rdy_clr;
  logic              err_set;
  logic              err_clr;
  logic              rd_hold_ld;
  logic              wait_comb;

  logic              jtag_any;
  logic              cpu_protected;
  logic              unused_jdo;

  assign jtag_any = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;

  // Writes into the upper region are only allowed from debug mode; others are silently acked.
  assign cpu_protected = ({{(32-ADDR_W){1'b0}}, avs_address} >= 32'(PROTECT_BASE))
                         & ~avs_debugaccess;

  // jdo carries command flags in [35:34]; [37:36] and [2:0] belong to other debug blocks.
  assign unused_jdo = ^{jdo[37:36], jdo[2:0]};

`ifdef OCIMEM_AUTOINC_EN
  assign ptr_inc = ptr + ADDR_W'(1);   // natural wrap at 2**ADDR_W-1 -> 0
`else
  assign ptr_inc = ptr;
`endif

  // ------------------------------------------------------------------
  // FSM state register
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // ------------------------------------------------------------------
  // FSM next-state and control decode
  // ------------------------------------------------------------------
  always_comb begin
    state_nxt  = state;
    ram_we     = 1'b0;
    ram_rd     = 1'b0;
    ram_be     = 4'h0;
    ram_addr   = ptr;
    ram_wdat   = wdat_q;
    ptr_ld     = 1'b0;
    ptr_step   = 1'b0;
    wdat_ld    = 1'b0;
    mon_cap    = 1'b0;
    rdy_set    = 1'b0;
    rdy_clr    = 1'b0;
    err_set    = 1'b0;
    err_clr    = 1'b0;
    rd_hold_ld = 1'b0;
    wait_comb  = 1'b1;

    case (state)
      S_IDLE: begin
        // JTAG has priority over the CPU; among JTAG pulses b > a > no_action.
        if (take_action_ocimem_b) begin
          state_nxt = S_JWR;
          wdat_ld   = 1'b1;
          rdy_clr   = 1'b1;
          err_set   = take_action_ocimem_a | take_no_action_ocimem_a;
        end else if (take_action_ocimem_a) begin
          err_set = take_no_action_ocimem_a;
          if (jdo[35]) begin
            ptr_ld  = 1'b1;
            rdy_clr = 1'b1;
            err_clr = 1'b1;
            if (jdo[34]) begin
              state_nxt = S_JRD;
            end
          end
        end else if (take_no_action_ocimem_a) begin
          state_nxt = S_JRD;
          rdy_clr   = 1'b1;
        end else if (avs_read) begin
          state_nxt = S_CRD;
        end else if (avs_write) begin
          // Single-cycle CPU write; protected writes are acked without touching the RAM.
          wait_comb = 1'b0;
          ram_we    = ~cpu_protected;
          ram_addr  = avs_address;
          ram_wdat  = avs_writedata;
          ram_be    = avs_byteenable;
        end
      end

      S_JRD: begin
        ram_rd    = 1'b1;
        ram_addr  = ptr;
        ptr_step  = 1'b1;
        state_nxt = S_JCAP;
      end

      S_JCAP: begin
        mon_cap   = 1'b1;
        rdy_set   = 1'b1;
        state_nxt = S_IDLE;
      end

      S_JWR: begin
        ram_we    = 1'b1;
        ram_addr  = ptr;
        ram_wdat  = wdat_q;
        ram_be    = 4'hF;
        ptr_step  = 1'b1;
        rdy_set   = 1'b1;
        state_nxt = S_IDLE;
      end

      S_CRD: begin
        ram_rd    = 1'b1;
        ram_addr  = avs_address;
        state_nxt = S_CDONE;
      end

      S_CDONE: begin
        wait_comb  = 1'b0;
        rd_hold_ld = 1'b1;
        state_nxt  = S_IDLE;
      end

      default: begin
        state_nxt = S_IDLE;
      end
    endcase

    // Busy with a previous access: any JTAG pulse is lost.
    if (state != S_IDLE) begin
      err_set = jtag_any;
    end
  end

  // ------------------------------------------------------------------
  // Pointer, JTAG result and status registers
  // ------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      ptr           <= ADDR_W'(RESET_ADDR);
      wdat_q        <= 32'h0;
      MonDReg       <= 32'h0;
      monitor_ready <= 1'b0;
      monitor_error <= 1'b0;
      rd_hold       <= 32'h0;
    end else begin
      if (ptr_ld) begin
        ptr <= jdo[26 +: ADDR_W];
      end else if (ptr_step) begin
        ptr <= ptr_inc;
      end

      if (wdat_ld) begin
        wdat_q <= jdo[34:3];
      end

      if (mon_cap) begin
        MonDReg <= rd_q;
      end

      if (rdy_set) begin
        monitor_ready <= 1'b1;
      end else if (rdy_clr) begin
        monitor_ready <= 1'b0;
      end

      // A drop in the same cycle as an address load must stay visible.
      if (err_set) begin
        monitor_error <= 1'b1;
      end else if (err_clr) begin
        monitor_error <= 1'b0;
      end

      if (rd_hold_ld) begin
        rd_hold <= rd_q;
      end
    end
  end

  // ------------------------------------------------------------------
  // Single-port RAM with registered read; never written while reset is asserted
  // ------------------------------------------------------------------
  assign ram_we_g = ram_we & reset_n;

  always_ff @(posedge clk) begin
    if (ram_we_g) begin
      for (int i = 0; i < 4; i++) begin
        if (ram_be[i]) begin
          mem[ram_addr][8*i +: 8] <= ram_wdat[8*i +: 8];
        end
      end
    end
    if (ram_rd) begin
      rd_q <= mem[ram_addr];
    end
  end

  // ------------------------------------------------------------------
  // CPU outputs
  // ------------------------------------------------------------------
  // Fresh RAM data is presented during CDONE; afterwards the held copy is shown.
  assign avs_readdata    = (state == S_CDONE) ? rd_q : rd_hold;
  assign avs_waitrequest = ~reset_n | wait_comb;

endmodule

// File: tb/tb_ltc5548_sys_nios2_gen2_0_cpu_debug_ocimem.sv
module tb_ltc5548_sys_nios2_gen2_0_cpu_debug_ocimem;

  logic        clk;
  logic        reset_n;
  logic [37:0] jdo;
  logic        take_action_ocimem_a;
  logic        take_action_ocimem_b;
  logic        take_no_action_ocimem_a;
  logic [7:0]  avs_address;
  logic        avs_read;
  logic        avs_write;
  logic [31:0] avs_writedata;
  logic [3:0]  avs_byteenable;
  logic        avs_debugaccess;
  logic [31:0] avs_readdata;
  logic        avs_waitrequest;
  logic [31:0] MonDReg;
  logic        monitor_ready;
  logic        monitor_error;

  int checks;
  int errors;

  ltc5548_sys_nios2_gen2_0_cpu_debug_ocimem #(
    .ADDR_W       (8),
    .RESET_ADDR   (0),
    .PROTECT_BASE (8'hC0)
  ) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_debugaccess         (avs_debugaccess),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  typedef struct {
    logic [7:0]  addr;
    logic [31:0] init;
    logic [31:0] wdat;
    logic [3:0]  be;
    logic        dbg;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs [7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [37:0] mk_load(input logic [7:0] a, input logic rd);
    logic [37:0] d;
    d        = '0;
    d[35]    = 1'b1;
    d[34]    = rd;
    d[33:26] = a;
    return d;
  endfunction

  function automatic logic [37:0] mk_wr(input logic [31:0] data);
    logic [37:0] d;
    d       = '0;
    d[34:3] = data;
    return d;
  endfunction

  // Drive one 1-cycle pulse; returns at edge E0 + 1.
  task automatic pulse(input logic a, input logic b, input logic na, input logic [37:0] d);
    take_action_ocimem_a    = a;
    take_action_ocimem_b    = b;
    take_no_action_ocimem_a = na;
    jdo                     = d;
    tick();
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
  endtask

  task automatic jtag_load(input logic [7:0] a);
    pulse(1'b1, 1'b0, 1'b0, mk_load(a, 1'b0));
  endtask

  task automatic jtag_write(input logic [31:0] data);
    pulse(1'b0, 1'b1, 1'b0, mk_wr(data));
    tick();
  endtask

  task automatic jtag_load_read(input logic [7:0] a, output logic [31:0] data);
    pulse(1'b1, 1'b0, 1'b0, mk_load(a, 1'b1));
    tick();
    tick();
    data = MonDReg;
  endtask

  task automatic cpu_write(input logic [7:0] a, input logic [31:0] data, input logic [3:0] be,
                           input logic dbg, output int waits);
    int n;
    avs_address     = a;
    avs_writedata   = data;
    avs_byteenable  = be;
    avs_debugaccess = dbg;
    avs_write       = 1'b1;
    n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL cpu_write_timeout: waitrequest stuck at 1 addr %h", a);
    end
    @(posedge clk);
    #1;
    avs_write = 1'b0;
    waits = n;
  endtask

  task automatic cpu_read(input logic [7:0] a, output logic [31:0] data, output int waits);
    int n;
    avs_address = a;
    avs_read    = 1'b1;
    n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < 20) begin
      n++;
      @(negedge clk);
    end
    if (n >= 20) begin
      checks++;
      errors++;
      $display("FAIL cpu_read_timeout: waitrequest stuck at 1 addr %h", a);
    end
    data = avs_readdata;
    @(posedge clk);
    #1;
    avs_read = 1'b0;
    waits = n;
  endtask

  initial begin
    logic [31:0] d;
    logic [31:0] exp_ram0;
    int          w;
    int          n;

    checks = 0;
    errors = 0;

    vecs[0] = '{addr: 8'h05, init: 32'h0000_0000, wdat: 32'hA5A5_A5A5, be: 4'hF, dbg: 1'b0, exp: 32'hA5A5_A5A5};
    vecs[1] = '{addr: 8'h06, init: 32'h1122_3344, wdat: 32'hAABB_CCDD, be: 4'h1, dbg: 1'b0, exp: 32'h1122_33DD};
    vecs[2] = '{addr: 8'h07, init: 32'h1122_3344, wdat: 32'hAABB_CCDD, be: 4'hA, dbg: 1'b0, exp: 32'hAA22_CC44};
    vecs[3] = '{addr: 8'hC0, init: 32'h0102_0304, wdat: 32'hFFFF_FFFF, be: 4'hF, dbg: 1'b0, exp: 32'h0102_0304};
    vecs[4] = '{addr: 8'hBF, init: 32'h0102_0304, wdat: 32'hFFFF_FFFF, be: 4'hF, dbg: 1'b0, exp: 32'hFFFF_FFFF};
    vecs[5] = '{addr: 8'hC0, init: 32'h0000_0000, wdat: 32'h1357_9BDF, be: 4'hF, dbg: 1'b1, exp: 32'h1357_9BDF};
    vecs[6] = '{addr: 8'hFF, init: 32'h1234_5678, wdat: 32'hBEEF_0000, be: 4'hC, dbg: 1'b1, exp: 32'hBEEF_5678};

    reset_n                 = 1'b0;
    jdo                     = '0;
    take_action_ocimem_a    = 1'b0;
    take_action_ocimem_b    = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    avs_address             = '0;
    avs_read                = 1'b0;
    avs_write               = 1'b0;
    avs_writedata           = '0;
    avs_byteenable          = 4'hF;
    avs_debugaccess         = 1'b0;

    // Reset state
    repeat (2) tick();
    chk("rst_mondreg", MonDReg, 32'h0);
    chk("rst_ready", {31'b0, monitor_ready}, 32'h0);
    chk("rst_error", {31'b0, monitor_error}, 32'h0);
    chk("rst_wait", {31'b0, avs_waitrequest}, 32'h1);
    chk("rst_rdata", avs_readdata, 32'h0);
    reset_n = 1'b1;
    tick();

    // Table: JTAG init, CPU write (byte lanes / protection), read back via CPU and JTAG
    for (int i = 0; i < 7; i++) begin
      jtag_load(vecs[i].addr);
      jtag_write(vecs[i].init);
      cpu_write(vecs[i].addr, vecs[i].wdat, vecs[i].be, vecs[i].dbg, w);
      chk($sformatf("vec%0d_wr_waits", i), 32'(w), 32'h0);
      cpu_read(vecs[i].addr, d, w);
      chk($sformatf("vec%0d_cpu_rd", i), d, vecs[i].exp);
      jtag_load_read(vecs[i].addr, d);
      chk($sformatf("vec%0d_jtag_rd", i), d, vecs[i].exp);
    end
    avs_byteenable  = 4'hF;
    avs_debugaccess = 1'b1;

    // 1: JTAG write then CPU read; pointer behaviour checked with a no_action read
    cpu_write(8'h11, 32'h1111_1111, 4'hF, 1'b1, w);
    jtag_load(8'h10);
    jtag_write(32'hDEAD_BEEF);
    chk("t1_ready_after_wr", {31'b0, monitor_ready}, 32'h1);
    cpu_read(8'h10, d, w);
    chk("t1_cpu_rd", d, 32'hDEAD_BEEF);
    chk("t1_cpu_rd_waits", 32'(w), 32'h2);
    pulse(1'b0, 1'b0, 1'b1, '0);
    tick();
    tick();
`ifdef OCIMEM_AUTOINC_EN
    chk("t1_ptr_next", MonDReg, 32'h1111_1111);
`else
    chk("t1_ptr_next", MonDReg, 32'hDEAD_BEEF);
`endif

    // 2: JTAG read latency exactly 2 cycles
    cpu_write(8'h11, 32'h1234_5678, 4'hF, 1'b1, w);
    pulse(1'b1, 1'b0, 1'b0, mk_load(8'h11, 1'b1));
    tick();
    chk("t2_ready_n1", {31'b0, monitor_ready}, 32'h0);
    tick();
    chk("t2_ready_n2", {31'b0, monitor_ready}, 32'h1);
    chk("t2_mondreg", MonDReg, 32'h1234_5678);

    // 3: pointer wrap
    cpu_write(8'h00, 32'h00C0_FFEE, 4'hF, 1'b1, w);
    jtag_load(8'hFF);
    jtag_write(32'hAAAA_0001);
    jtag_write(32'hBBBB_0002);
`ifdef OCIMEM_AUTOINC_EN
    exp_ram0 = 32'hBBBB_0002;
    cpu_read(8'hFF, d, w);
    chk("t3_ram_ff", d, 32'hAAAA_0001);
`else
    exp_ram0 = 32'h00C0_FFEE;
    cpu_read(8'hFF, d, w);
    chk("t3_ram_ff", d, 32'hBBBB_0002);
`endif
    cpu_read(8'h00, d, w);
    chk("t3_ram_00", d, exp_ram0);

    // 4: JTAG write and CPU read in the same cycle
    jtag_load(8'h20);
    take_action_ocimem_b = 1'b1;
    jdo                  = mk_wr(32'hCAFE_0001);
    avs_address          = 8'h20;
    avs_read             = 1'b1;
    @(negedge clk);
    chk("t4_wait_jtag_wins", {31'b0, avs_waitrequest}, 32'h1);
    tick();
    take_action_ocimem_b = 1'b0;
    n = 0;
    @(negedge clk);
    while (avs_waitrequest && n < 20) begin
      n++;
      @(negedge clk);
    end
    chk("t4_no_timeout", {31'b0, (n < 20)}, 32'h1);
    chk("t4_cpu_rd", avs_readdata, 32'hCAFE_0001);
    tick();
    avs_read = 1'b0;

    // 5: collision drops ocimem_a; a busy-state pulse is dropped too; address loads clear
    jtag_load(8'h30);
    jdo     = mk_wr(32'h5A5A_5A5A);
    jdo[35] = 1'b1;
    pulse(1'b1, 1'b1, 1'b0, jdo);
    chk("t5_err_collide", {31'b0, monitor_error}, 32'h1);
    tick();
    cpu_read(8'h30, d, w);
    chk("t5_write_won", d, 32'h5A5A_5A5A);
    jtag_load(8'h50);
    chk("t5_err_cleared", {31'b0, monitor_error}, 32'h0);
    pulse(1'b0, 1'b1, 1'b0, mk_wr(32'h0));
    pulse(1'b0, 1'b0, 1'b1, '0);
    chk("t5_err_busy", {31'b0, monitor_error}, 32'h1);
    jtag_load(8'h50);
    chk("t5_err_cleared2", {31'b0, monitor_error}, 32'h0);

    // 6: protected write, then reset in the middle of a CPU read
    cpu_write(8'hF0, 32'h7777_7777, 4'hF, 1'b1, w);
    cpu_write(8'hF0, 32'h0000_0055, 4'hF, 1'b0, w);
    chk("t6_prot_waits", 32'(w), 32'h0);
    cpu_read(8'hF0, d, w);
    chk("t6_prot_unchanged", d, 32'h7777_7777);
    avs_address = 8'h10;
    avs_read    = 1'b1;
    tick();
    reset_n = 1'b0;
    #2;
    chk("t6_rst_wait", {31'b0, avs_waitrequest}, 32'h1);
    chk("t6_rst_mondreg", MonDReg, 32'h0);
    chk("t6_rst_rdata", avs_readdata, 32'h0);
    avs_read = 1'b0;
    tick();
    reset_n = 1'b1;
    tick();
    pulse(1'b0, 1'b0, 1'b1, '0);
    tick();
    tick();
    chk("t6_ptr_reset", MonDReg, exp_ram0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
